pipelined_addsub: RTL and testbench

Parametrised, pipelined integer adder/subtractor for the RISC datapath. It replaces the single-cycle 32-bit adder where timing demands it. The carry chain is split into STAGES equal chunks, with one chunk resolved per register stage. It accepts one operation per cycle under a valid/ready handshake and returns the sum plus carry, signed-overflow and zero flags.

---
 rtl/pipelined_addsub.sv | 113 +++++++++++
 tb/tb_pipelined_addsub.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES chunks, one chunk per register stage.
// Operands skew forward with the pipe and finished sum chunks de-skew alongside; flags come from the final stage.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = WIDTH / STAGES;

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_v [STAGES];
    logic             r_c [STAGES];
    logic             r_ovf;
    logic             r_zero;

    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_c_in  [STAGES];
    logic             w_v_in  [STAGES];
    logic             w_c_nxt [STAGES];
    logic [CW:0]      w_chunk [STAGES];
    logic             w_stall;
    logic             w_en;
    logic             w_msb_cin;
    logic             w_ovf_nxt;
    logic             w_zero_nxt;

    // A full output slot that is not being taken freezes the whole pipe.
    assign w_stall  = r_v[STAGES-1] && !out_ready;
    assign w_en     = !w_stall;
    assign in_ready = !w_stall;

    always_comb begin
        w_a_in[0] = A;
        w_b_in[0] = sub ? ~B : B;
        w_c_in[0] = sub ^ c_in;
        w_s_in[0] = '0;
        w_v_in[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_c_in[k] = r_c[k-1];
            w_s_in[k] = r_s[k-1];
            w_v_in[k] = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k] = {1'b0, w_a_in[k][k*CW +: CW]} + {1'b0, w_b_in[k][k*CW +: CW]}
                       + {{CW{1'b0}}, w_c_in[k]};
            w_s_nxt[k] = w_s_in[k];
            w_s_nxt[k][k*CW +: CW] = w_chunk[k][CW-1:0];
            w_c_nxt[k] = w_chunk[k][CW];
        end
        // Carry into the MSB is recovered from the MSB's own sum bit and operands.
        w_msb_cin  = w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1]
                   ^ w_s_nxt[STAGES-1][WIDTH-1];
        w_ovf_nxt  = w_msb_cin ^ w_c_nxt[STAGES-1];
        w_zero_nxt = (w_s_nxt[STAGES-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                    r_s[k] <= w_s_nxt[k];
                    r_c[k] <= w_c_nxt[k];
                end
            end
            if (w_v_in[STAGES-1]) begin
                r_ovf  <= w_ovf_nxt;
                r_zero <= w_zero_nxt;
            end
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign c_out     = r_c[STAGES-1];
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: three instances (32/4, 32/1, 16/2) fed in lockstep; a monitor per instance checks results.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid = 1'b0;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [15:0] A16 = '0;
    logic [15:0] B16 = '0;
    logic        iv_s;

    logic        m_in_ready, m_out_valid, m_c_out, m_overflow, m_zero;
    logic [31:0] m_sum;
    logic        s1_in_ready, s1_out_valid, s1_c_out, s1_overflow, s1_zero;
    logic [31:0] s1_sum;
    logic        s2_in_ready, s2_out_valid, s2_c_out, s2_overflow, s2_zero;
    logic [15:0] s2_sum;

    // Secondary instances never stall, so they accept exactly when the main one does.
    assign iv_s = in_valid && m_in_ready;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .A(A), .B(B), .c_in(c_in), .sub(sub), .out_valid(m_out_valid), .out_ready(out_ready),
        .sum(m_sum), .c_out(m_c_out), .overflow(m_overflow), .zero(m_zero));

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(s1_in_ready),
        .A(A), .B(B), .c_in(c_in), .sub(sub), .out_valid(s1_out_valid), .out_ready(1'b1),
        .sum(s1_sum), .c_out(s1_c_out), .overflow(s1_overflow), .zero(s1_zero));

    pipelined_addsub #(.WIDTH(16), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(s2_in_ready),
        .A(A16), .B(B16), .c_in(c_in), .sub(sub), .out_valid(s2_out_valid), .out_ready(1'b1),
        .sum(s2_sum), .c_out(s2_c_out), .overflow(s2_overflow), .zero(s2_zero));

    typedef struct {
        logic [31:0] s;
        logic [2:0]  f;
        int          acc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic        ci, sb;
        logic [31:0] s;
        logic [2:0]  f;
        logic [15:0] a2, b2, s2;
        logic [2:0]  f2;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;
    vec_t vt[9];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   nobp = 1'b1;
    bit   seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic issue(input vec_t v);
        bit done;
        int ac;
        done = 1'b0;
        A = v.a; B = v.b; c_in = v.ci; sub = v.sb; A16 = v.a2; B16 = v.b2;
        in_valid = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (m_in_ready) begin
                ac = cyc;
                @(posedge clk);
                q0.push_back('{v.s, v.f, ac, nobp});
                q1.push_back('{v.s, v.f, ac, 1'b1});
                q2.push_back('{{16'h0, v.s2}, v.f2, ac, 1'b1});
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        #1;
        in_valid = 1'b0;
        if (!done) fail("accept_timeout");
    endtask

    task automatic stream(input int base, input int n);
        vec_t v;
        int   i;
        for (int k = 0; k < n; k++) begin
            i = base + k;
            v = '{32'(i), 32'(i << 16), 1'b0, 1'b0, 32'(i + (i << 16)), {2'b00, i == 0},
                  16'(i), 16'(i << 8), 16'(i + (i << 8)), {2'b00, i == 0}};
            issue(v);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (q0.size() + q1.size() + q2.size()) != 0; t++) @(posedge clk);
        if ((q0.size() + q1.size() + q2.size()) != 0) fail("drain_timeout");
        #1;
    endtask

    task automatic chk_zero_out(input string nm);
        chk({nm, "_main"}, 64'({m_out_valid, m_sum, m_c_out, m_overflow, m_zero}), 64'(0));
        chk({nm, "_s1"}, 64'({s1_out_valid, s1_sum, s1_c_out, s1_overflow, s1_zero}), 64'(0));
        chk({nm, "_s2"}, 64'({s2_out_valid, s2_sum, s2_c_out, s2_overflow, s2_zero}), 64'(0));
    endtask

    // Main monitor: results in order, latency, hold-stability under stall, in_ready rule.
    logic        pv_stall = 1'b0;
    logic [34:0] p_out = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_in_ready", 64'(m_in_ready), 64'(!(m_out_valid && !out_ready)));
            if (m_out_valid) begin
                if (pv_stall)
                    chk("m_hold", 64'({m_sum, m_c_out, m_overflow, m_zero}), 64'(p_out));
                if (q0.size() == 0) begin
                    fail("m_unexpected_output");
                end else begin
                    e0 = q0[0];
                    chk("m_result", 64'({m_sum, m_c_out, m_overflow, m_zero}), 64'({e0.s, e0.f}));
                    if (!pv_stall && e0.lat) chk("m_latency", 64'(cyc - e0.acc), 64'(4));
                    if (out_ready) q0.delete(0);
                end
            end
            pv_stall <= m_out_valid && !out_ready;
            p_out    <= {m_sum, m_c_out, m_overflow, m_zero};
        end else begin
            pv_stall <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && s1_out_valid) begin
            if (q1.size() == 0) begin
                fail("s1_unexpected_output");
            end else begin
                e1 = q1[0];
                chk("s1_result", 64'({s1_sum, s1_c_out, s1_overflow, s1_zero}), 64'({e1.s, e1.f}));
                chk("s1_latency", 64'(cyc - e1.acc), 64'(1));
                q1.delete(0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s2_out_valid) begin
            if (q2.size() == 0) begin
                fail("s2_unexpected_output");
            end else begin
                e2 = q2[0];
                chk("s2_result", 64'({s2_sum, s2_c_out, s2_overflow, s2_zero}), 64'({e2.s[15:0], e2.f}));
                chk("s2_latency", 64'(cyc - e2.acc), 64'(2));
                q2.delete(0);
            end
        end
    end

    initial begin
        // f fields are {c_out, overflow, zero}
        vt[0] = '{32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'hC000_0000, 3'b000, 16'h8000, 16'h4000, 16'hC000, 3'b000};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 3'b101, 16'hFFFF, 16'h0001, 16'h0000, 3'b101};
        vt[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 3'b010, 16'h7FFF, 16'h0001, 16'h8000, 3'b010};
        vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 3'b000, 16'h0005, 16'h0007, 16'hFFFE, 3'b000};
        vt[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 3'b100, 16'h0007, 16'h0005, 16'h0001, 3'b100};
        vt[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 3'b110, 16'h8000, 16'h0001, 16'h7FFF, 3'b110};
        vt[6] = '{32'h1234_5678, 32'h0000_0001, 1'b1, 1'b0, 32'h1234_567A, 3'b000, 16'h5678, 16'h0001, 16'h567A, 3'b000};
        vt[7] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 3'b000, 16'h00FF, 16'h0001, 16'h0100, 3'b000};
        vt[8] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 3'b101, 16'h0005, 16'h0005, 16'h0000, 3'b101};

        repeat (2) @(negedge clk);
        chk_zero_out("reset_state");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(m_in_ready), 64'(1));
        @(posedge clk);
        #1;

        for (int r = 0; r < 9; r++) issue(vt[r]);
        stream(0, 8);
        drain();

        nobp = 1'b0;
        out_ready = 1'b0;
        seen = 1'b0;
        fork
            stream(16, 6);
            begin
                for (int t = 0; t < 40 && !seen; t++) begin
                    @(negedge clk);
                    seen = m_out_valid;
                end
                if (!seen) fail("bp_wait_valid");
                repeat (4) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        nobp = 1'b1;

        issue(vt[0]);
        issue(vt[1]);
        issue(vt[2]);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(m_out_valid), 64'(1));
        q0.delete();
        q1.delete();
        q2.delete();
        rst_n = 1'b0;
        #1;
        chk_zero_out("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        issue(vt[3]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
